gate_scheduler: RTL and testbench
=================================

GATE_SCHEDULER -- requirements
Module: gate_scheduler

Interface
REQ-001 Parameter GATE_CYCLES, default 400000000, SHALL set the gate-open duration in clk cycles (10 s at 40 MHz).
REQ-002 Parameter FULL_CYCLES, default 240000000, SHALL set the full-indication hold duration in clk cycles (6 s at 40 MHz).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port reset  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 Port entry_req  input  1  SHALL be a level request from the entry sensor, held by the requester until it is granted or rejected.
REQ-006 Port exit_req  input  1  SHALL be a level request from the exit sensor, held until it is granted or rejected.
REQ-007 Port exit_slot  input  2  SHALL give the slot being vacated; it is valid while exit_req=1.
REQ-008 Port entry_grant  output  1  SHALL be a one-cycle pulse that accepts an entry.
REQ-009 Port exit_grant  output  1  SHALL be a one-cycle pulse that accepts an exit.
REQ-010 Port reject  output  1  SHALL be a one-cycle pulse that refuses a request.
REQ-011 Port grant_slot  output  2  SHALL give the slot allocated or freed; it is valid with a grant pulse and held until the next grant.
REQ-012 Port gate_open  output  1  SHALL be high while the shared gate is open.
REQ-013 Port full_flag  output  1  SHALL be high during the full hold.
REQ-014 Port occupancy  output  4  SHALL give the per-slot occupied bits.
REQ-015 Port capacity  output  3  SHALL give the number of free slots, 0..4.

Function
REQ-016 The FSM SHALL have exactly three states (IDLE, GATE_OPEN, FULL_HOLD) and SHALL sample requests only in IDLE.
REQ-017 Entry accepted in IDLE at edge n, with a free slot available:
- entry_grant=1 during cycle n+1;
- grant_slot = lowest-index free slot;
- that occupancy bit set at edge n;
- state -> GATE_OPEN.
REQ-018 Exit accepted in IDLE at edge n, with occupancy[exit_slot]=1:
- exit_grant=1 during cycle n+1;
- grant_slot = exit_slot;
- that occupancy bit cleared at edge n;
- state -> GATE_OPEN.
REQ-019 gate_open SHALL be high for exactly GATE_CYCLES cycles, starting at cycle n+1; the FSM then returns to IDLE and SHALL accept a new request in the first IDLE cycle.
REQ-020 An entry when capacity=0 SHALL pulse reject, leave occupancy unchanged, and hold full_flag=1 in FULL_HOLD for exactly FULL_CYCLES cycles before returning to IDLE.
REQ-021 An exit to an unoccupied slot SHALL pulse reject for one cycle, leave occupancy unchanged, and keep the state IDLE.
REQ-022 Simultaneous entry_req and exit_req in IDLE SHALL be arbitrated round-robin: the class not served last wins, and the loser stays pending.
REQ-023 After reset the last-served class SHALL be entry, so exit wins the first tie.
REQ-024 Only a grant SHALL update the round-robin pointer; a reject SHALL NOT.
REQ-025 Requests asserted during GATE_OPEN or FULL_HOLD SHALL be ignored until IDLE; no grant, reject or occupancy change occurs outside IDLE.
REQ-026 capacity SHALL equal 4 minus popcount(occupancy) at all times, never exceeding 4 or underflowing.
REQ-027 At most one of entry_grant, exit_grant and reject SHALL be high in any cycle.

Reset
REQ-028 Reset SHALL force, immediately on assertion and with no clock required, all of the following:
- state IDLE, occupancy 0000, capacity 4;
- grant_slot 0;
- all pulses 0, gate_open 0, full_flag 0;
- timers 0, round-robin pointer = entry.
REQ-029 Reset asserted mid-GATE_OPEN or mid-FULL_HOLD SHALL abort the operation; the first request after deassertion SHALL be serviced as from power-up.

Structure
REQ-030 A shared package gate_pkg SHALL hold the state enum, NUM_SLOTS=4, the slot-index width (2) and the capacity width (3).
REQ-031 One sub-module, gate_timer, SHALL implement a loadable down-counter with a done flag, shared by GATE_OPEN and FULL_HOLD (32-bit count).

Verification (bench uses GATE_CYCLES=8, FULL_CYCLES=5)
REQ-032 Four sequential entries SHALL produce grant_slot 0,1,2,3, occupancy 1111 and capacity 0, with gate_open high exactly 8 cycles per entry.
REQ-033 A fifth entry with capacity 0 SHALL pulse reject and hold full_flag high exactly 5 cycles, with occupancy unchanged.
REQ-034 With occupancy 1111, exit_slot=1 SHALL give exit_grant with grant_slot=1, occupancy 1101 and capacity 1; a following entry SHALL get grant_slot=1.
REQ-035 entry_req and exit_req raised together after reset SHALL grant the exit first, then the entry after the gate closes.
REQ-036 exit_slot=2 with occupancy 0001 SHALL pulse reject for one cycle, leave the state IDLE and leave occupancy 0001.
REQ-037 Reset asserted in the 4th gate_open cycle SHALL drop gate_open immediately, with occupancy 0000 and capacity 4.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared types and sizing for the single-gate parking slot scheduler.
package gate_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;
  localparam int unsigned CAP_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    GATE_OPEN,
    FULL_HOLD
  } state_e;

  typedef enum logic {
    CLS_ENTRY,
    CLS_EXIT
  } req_class_e;

  function automatic logic [CAP_W-1:0] free_count(input logic [NUM_SLOTS-1:0] occ);
    logic [CAP_W-1:0] c;
    c = CAP_W'(NUM_SLOTS);
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      c = c - CAP_W'(occ[i]);
    end
    return c;
  endfunction

  // Descending scan so the last hit, and therefore the result, is the lowest free index.
  function automatic logic [SLOT_W-1:0] lowest_free(input logic [NUM_SLOTS-1:0] occ);
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
      if (!occ[i-1]) idx = SLOT_W'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter; done_o marks the final cycle of a loaded interval.
module gate_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q <= WIDTH'(1));

endmodule

// File: rtl/gate_scheduler.sv
// Slot scheduler for a shared entry/exit gate: round-robin arbitration,
// per-slot occupancy, timed gate-open and full-indication holds.
module gate_scheduler
  import gate_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 400000000,
  parameter int unsigned FULL_CYCLES = 240000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic                 entry_grant,
  output logic                 exit_grant,
  output logic                 reject,
  output logic [SLOT_W-1:0]    grant_slot,
  output logic                 gate_open,
  output logic                 full_flag,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [CAP_W-1:0]     capacity
);

  state_e               state_q, state_d;
  logic [NUM_SLOTS-1:0] occ_q, occ_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  req_class_e           last_q, last_d;
  logic                 eg_q, eg_d;
  logic                 xg_q, xg_d;
  logic                 rej_q, rej_d;

  logic                 serve_exit;
  logic                 serve_entry;
  logic [SLOT_W-1:0]    free_idx;
  logic                 tmr_load;
  logic [31:0]          tmr_val;
  logic                 tmr_done;

  gate_timer #(.WIDTH(32)) u_timer (
    .clk        (clk),
    .rst        (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the registered datapath updates that accompany each decision.
  always_comb begin
    state_d     = state_q;
    occ_d       = occ_q;
    slot_d      = slot_q;
    last_d      = last_q;
    eg_d        = 1'b0;
    xg_d        = 1'b0;
    rej_d       = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    serve_exit  = 1'b0;
    serve_entry = 1'b0;
    free_idx    = lowest_free(occ_q);
    case (state_q)
      IDLE: begin
        // On a tie the class not served last wins; the loser keeps its request up.
        serve_exit  = exit_req && (!entry_req || (last_q == CLS_ENTRY));
        serve_entry = entry_req && !serve_exit;
        if (serve_exit) begin
          if (occ_q[exit_slot]) begin
            occ_d[exit_slot] = 1'b0;
            slot_d           = exit_slot;
            last_d           = CLS_EXIT;
            xg_d             = 1'b1;
            state_d          = GATE_OPEN;
            tmr_load         = 1'b1;
            tmr_val          = 32'(GATE_CYCLES);
          end else begin
            rej_d = 1'b1;
          end
        end else if (serve_entry) begin
          if (occ_q != '1) begin
            occ_d[free_idx] = 1'b1;
            slot_d          = free_idx;
            last_d          = CLS_ENTRY;
            eg_d            = 1'b1;
            state_d         = GATE_OPEN;
            tmr_load        = 1'b1;
            tmr_val         = 32'(GATE_CYCLES);
          end else begin
            rej_d    = 1'b1;
            state_d  = FULL_HOLD;
            tmr_load = 1'b1;
            tmr_val  = 32'(FULL_CYCLES);
          end
        end
      end
      GATE_OPEN, FULL_HOLD: begin
        if (tmr_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q  <= '0;
      slot_q <= '0;
      last_q <= CLS_ENTRY;
      eg_q   <= 1'b0;
      xg_q   <= 1'b0;
      rej_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      slot_q <= slot_d;
      last_q <= last_d;
      eg_q   <= eg_d;
      xg_q   <= xg_d;
      rej_q  <= rej_d;
    end
  end

  always_comb begin
    gate_open   = (state_q == GATE_OPEN);
    full_flag   = (state_q == FULL_HOLD);
    entry_grant = eg_q;
    exit_grant  = xg_q;
    reject      = rej_q;
    grant_slot  = slot_q;
    occupancy   = occ_q;
    capacity    = free_count(occ_q);
  end

endmodule

// File: tb/tb_gate_scheduler.sv
// Directed scoreboard bench for gate_scheduler with short gate/full holds.
module tb_gate_scheduler;

  localparam int GATE = 8;
  localparam int FULL = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_req;
  logic       exit_req;
  logic [1:0] exit_slot;
  logic       entry_grant;
  logic       exit_grant;
  logic       reject;
  logic [1:0] grant_slot;
  logic       gate_open;
  logic       full_flag;
  logic [3:0] occupancy;
  logic [2:0] capacity;

  int checks   = 0;
  int failures = 0;

  // kind: 0 entry grant, 1 exit grant, 2 reject; cls: 0 entry request, 1 exit request
  typedef struct {
    int         cls;
    int         kind;
    logic [1:0] slot;
    logic [3:0] occ;
    logic [2:0] cap;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] occ_m;
  logic [1:0] slot_m;

  gate_scheduler #(.GATE_CYCLES(GATE), .FULL_CYCLES(FULL)) dut (
    .clk         (clk),
    .reset       (reset),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .exit_slot   (exit_slot),
    .entry_grant (entry_grant),
    .exit_grant  (exit_grant),
    .reject      (reject),
    .grant_slot  (grant_slot),
    .gate_open   (gate_open),
    .full_flag   (full_flag),
    .occupancy   (occupancy),
    .capacity    (capacity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] model_cap(input logic [3:0] occ);
    return 3'(4 - $countones(occ));
  endfunction

  task automatic request_entry();
    exp_t e;
    e.cls = 0;
    if (occ_m == 4'hF) begin
      e.kind = 2;
    end else begin
      e.kind = 0;
      for (int i = 3; i >= 0; i--) if (!occ_m[i]) slot_m = 2'(i);
      occ_m[slot_m] = 1'b1;
    end
    e.slot = slot_m;
    e.occ  = occ_m;
    e.cap  = model_cap(occ_m);
    sb.push_back(e);
    entry_req = 1'b1;
  endtask

  task automatic request_exit(input logic [1:0] s);
    exp_t e;
    e.cls = 1;
    if (occ_m[s]) begin
      e.kind   = 1;
      occ_m[s] = 1'b0;
      slot_m   = s;
    end else begin
      e.kind = 2;
    end
    e.slot = slot_m;
    e.occ  = occ_m;
    e.cap  = model_cap(occ_m);
    sb.push_back(e);
    exit_slot = s;
    exit_req  = 1'b1;
  endtask

  // Pops the oldest expectation, waits for the response pulse, then times the hold.
  task automatic serve(input string tag, input int abort_after);
    exp_t e;
    int   n;
    int   cnt;
    int   kind;
    logic seen;
    e    = sb.pop_front();
    seen = 1'b0;
    n    = 0;
    kind = -1;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      check({tag, "_excl"}, 32'($onehot0({entry_grant, exit_grant, reject})), 32'd1);
      if (entry_grant || exit_grant || reject) seen = 1'b1;
    end
    check({tag, "_resp_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      kind = entry_grant ? 0 : (exit_grant ? 1 : 2);
      if (e.cls == 0) entry_req = 1'b0;
      else            exit_req  = 1'b0;
      check({tag, "_kind"}, 32'(kind), 32'(e.kind));
      check({tag, "_slot"}, 32'(grant_slot), 32'(e.slot));
      check({tag, "_occ"},  32'(occupancy), 32'(e.occ));
      check({tag, "_cap"},  32'(capacity), 32'(e.cap));
      if (e.kind != 2) begin
        cnt = 0;
        while (gate_open && cnt < 100) begin
          cnt++;
          if (abort_after != 0 && cnt == abort_after) return;
          @(negedge clk);
        end
        check({tag, "_gate_len"}, 32'(cnt), 32'(GATE));
      end else if (e.cls == 0) begin
        cnt = 0;
        while (full_flag && cnt < 100) begin
          cnt++;
          @(negedge clk);
        end
        check({tag, "_full_len"}, 32'(cnt), 32'(FULL));
        check({tag, "_occ_after"}, 32'(occupancy), 32'(e.occ));
      end else begin
        check({tag, "_idle"}, 32'({gate_open, full_flag}), 32'd0);
        @(negedge clk);
        check({tag, "_rej_1cyc"}, 32'(reject), 32'd0);
        check({tag, "_idle_next"}, 32'({gate_open, full_flag}), 32'd0);
        check({tag, "_occ_next"}, 32'(occupancy), 32'(e.occ));
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_gate"},   32'(gate_open), 32'd0);
    check({tag, "_full"},   32'(full_flag), 32'd0);
    check({tag, "_occ"},    32'(occupancy), 32'd0);
    check({tag, "_cap"},    32'(capacity), 32'd4);
    check({tag, "_slot"},   32'(grant_slot), 32'd0);
    check({tag, "_pulses"}, 32'({entry_grant, exit_grant, reject}), 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state(tag);
    occ_m  = '0;
    slot_m = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_slot = '0;
    occ_m     = '0;
    slot_m    = '0;
    #2;
    check_reset_state("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      request_entry();
      serve($sformatf("entry%0d", i), 0);
    end
    check("fill_occ", 32'(occupancy), 32'hF);
    check("fill_cap", 32'(capacity), 32'd0);

    request_entry();
    serve("full_reject", 0);
    check("full_slot_held", 32'(grant_slot), 32'd3);

    request_exit(2'd1);
    serve("exit1", 0);
    request_entry();
    serve("refill1", 0);

    apply_reset("rst_a");
    request_entry();
    serve("entry_after_rst", 0);
    request_exit(2'd2);
    serve("exit_bad_slot", 0);

    request_exit(2'd0);
    request_entry();
    serve("tie_exit_first", 0);
    serve("tie_entry_second", 0);

    request_entry();
    serve("abort_entry", 4);
    check("abort_pre_gate", 32'(gate_open), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_state("abort");
    occ_m  = '0;
    slot_m = '0;
    @(negedge clk);
    reset = 1'b0;
    request_entry();
    serve("post_abort_entry", 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
